// File: rtl/sm4_mode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_mode_pkg
//  Description : Shared types and constants for the SM4 block-mode controller
//                (mode encoding, FSM state encoding, block width).
//  Revision    : 1.0 - initial release
// ============================================================================
package sm4_mode_pkg;

    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [1:0] {
        MODE_ECB     = 2'b00,
        MODE_CBC     = 2'b01,
        MODE_CTR     = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sm4_mode_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_mode_fifo
//  Description : Synchronous-reset output FIFO for processed blocks. Push and
//                pop in the same cycle are both honoured; pushes to a full
//                FIFO and pops from an empty FIFO are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm4_mode_fifo
    import sm4_mode_pkg::*;
#(
    parameter int unsigned Width = BLOCK_W,
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         i_push,
    input  logic [Width-1:0]             i_data,
    input  logic                         i_pop,
    output logic [Width-1:0]             o_data,
    output logic                         o_empty,
    output logic [$clog2(Depth+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(Depth);
    localparam int unsigned CNT_W = $clog2(Depth+1);

    logic [Width-1:0] r_mem [Depth];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_rd_next;

    assign w_push    = i_push & (r_count != CNT_W'(Depth));
    assign w_pop     = i_pop  & (r_count != '0);
    // Pointers wrap explicitly so non-power-of-two depths work.
    assign w_wr_next = (r_wr == PTR_W'(Depth-1)) ? '0 : r_wr + PTR_W'(1);
    assign w_rd_next = (r_rd == PTR_W'(Depth-1)) ? '0 : r_rd + PTR_W'(1);

    assign o_data  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= w_wr_next;
            end
            if (w_pop) begin
                r_rd <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm4_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_mode_ctrl
//  Description : ECB / CBC / CTR mode wrapper around an SM4 block core.
//                Accepts one block at a time, issues it to the core, applies
//                the mode post-processing and queues results in a FIFO.
//                A FIFO slot is reserved before issue, so a push can never
//                meet a full FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm4_mode_ctrl
    import sm4_mode_pkg::*;
#(
    parameter int unsigned Depth         = 4,
    parameter int unsigned CtrWidth      = 32,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [1:0]     mode_i,
    input  logic           dec_i,
    input  logic [127:0]   iv_i,
    input  logic           iv_load_i,
    input  logic           key_ready_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [127:0]   in_data_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [127:0]   out_data_o,
    output logic           core_req_o,
    output logic           core_dec_o,
    output logic [127:0]   core_data_o,
    input  logic           core_ack_i,
    input  logic [127:0]   core_result_i,
    output logic           busy_o,
    output logic           err_o
);

    localparam int unsigned CNT_W = $clog2(Depth+1);
    // Counter only needs to reach TimeoutCycles-2: one cycle is spent in
    // ISSUE and the expiry edge itself is the last WAIT cycle.
    localparam int unsigned TMO_W = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TimeoutCycles-2);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;

    logic [1:0]       r_state;
    logic [1:0]       r_mode;
    logic             r_dec;
    logic [127:0]     r_data;
    logic [127:0]     r_chain;
    logic [127:0]     r_core_data;
    logic             r_core_dec;
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    logic             w_idle;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_ack;
    logic             w_timeout;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [127:0]     w_core_in;
    logic             w_core_dec_in;
    logic [127:0]     w_push_data;
    logic [127:0]     w_chain_next;
    logic [127:0]     w_ctr_next;

    assign w_idle     = (r_state == S_IDLE);
    // Ready is held low while reset is asserted so nothing is accepted then.
    assign w_in_ready = rst_ni & w_idle & key_ready_i
                      & (w_fifo_count < CNT_W'(Depth))
                      & ~iv_load_i & (mode_i != MODE_ILLEGAL);
    assign w_accept   = in_valid_i & w_in_ready;
    assign w_ack      = (r_state == S_WAIT) & core_ack_i;
    assign w_timeout  = (r_state == S_WAIT) & ~core_ack_i & (r_tmo == TMO_LAST);

    // Core input chosen from the incoming block at accept time.
    always_comb begin
        w_core_in     = in_data_i;
        w_core_dec_in = dec_i;
        case (mode_i)
            MODE_CBC: w_core_in = dec_i ? in_data_i : (in_data_i ^ r_chain);
            MODE_CTR: begin
                w_core_in     = r_chain;
                w_core_dec_in = 1'b0;
            end
            default:  w_core_in = in_data_i;
        endcase
    end

    // Counter block advance: only the low CtrWidth bits increment.
    always_comb begin
        w_ctr_next                 = r_chain;
        w_ctr_next[CtrWidth-1:0]   = r_chain[CtrWidth-1:0] + {{(CtrWidth-1){1'b0}}, 1'b1};
    end

    // Result post-processing and next chain value on core ack.
    always_comb begin
        w_push_data  = core_result_i;
        w_chain_next = r_chain;
        case (r_mode)
            MODE_CBC: begin
                if (r_dec) begin
                    w_push_data  = core_result_i ^ r_chain;
                    w_chain_next = r_data;
                end else begin
                    w_chain_next = core_result_i;
                end
            end
            MODE_CTR: begin
                w_push_data  = core_result_i ^ r_data;
                w_chain_next = w_ctr_next;
            end
            default: w_push_data = core_result_i;
        endcase
    end

    // Block FSM: IDLE -> ISSUE -> WAIT -> IDLE, plus chain/IV handling.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_dec       <= 1'b0;
            r_data      <= '0;
            r_chain     <= '0;
            r_core_data <= '0;
            r_core_dec  <= 1'b0;
            r_tmo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iv_load_i) begin
                        r_chain <= iv_i;
                    end else if (w_accept) begin
                        r_mode      <= mode_i;
                        r_dec       <= dec_i;
                        r_data      <= in_data_i;
                        r_core_data <= w_core_in;
                        r_core_dec  <= w_core_dec_in;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_ack_i) begin
                        r_chain <= w_chain_next;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky error: set by timeout or illegal-mode input, cleared by IV load.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_idle & iv_load_i) begin
            r_err <= 1'b0;
        end else if (w_timeout | (in_valid_i & (mode_i == MODE_ILLEGAL))) begin
            r_err <= 1'b1;
        end
    end

    sm4_mode_fifo #(
        .Width (BLOCK_W),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_ack),
        .i_data  (w_push_data),
        .i_pop   (out_ready_i),
        .o_data  (out_data_o),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = ~w_fifo_empty;
    assign core_req_o  = (r_state == S_ISSUE);
    assign core_dec_o  = r_core_dec;
    assign core_data_o = r_core_data;
    assign busy_o      = ~w_idle;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sm4_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm4_mode_ctrl
//  Description : Directed self-checking bench for sm4_mode_ctrl with a core
//                model that acks 32 cycles after each request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm4_mode_ctrl;

    localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] PXC = 128'h693d9a535bad5bb1786f53d7253a7056;
    localparam logic [127:0] IVC = 128'h000000000000000000000000ffffffff;

    logic         clk = 1'b0;
    logic         rst_n, dec, iv_load, key_ready, in_valid, out_ready;
    logic [1:0]   mode;
    logic [127:0] iv, in_data;
    logic         in_ready, out_valid, core_req, core_dec, busy, err;
    logic [127:0] out_data, core_data;
    logic         core_ack = 1'b0;
    logic [127:0] core_result = '0;

    int           n_checks = 0;
    int           n_err    = 0;
    bit           m_en     = 1'b1;
    int           m_cnt    = 0;
    logic [127:0] m_data   = '0;
    logic         m_dec    = 1'b0;
    logic [127:0] req_data [$];
    logic         req_dec  [$];

    sm4_mode_ctrl dut (
        .clk_i (clk), .rst_ni (rst_n), .mode_i (mode), .dec_i (dec),
        .iv_i (iv), .iv_load_i (iv_load), .key_ready_i (key_ready),
        .in_valid_i (in_valid), .in_ready_o (in_ready), .in_data_i (in_data),
        .out_valid_o (out_valid), .out_ready_i (out_ready), .out_data_o (out_data),
        .core_req_o (core_req), .core_dec_o (core_dec), .core_data_o (core_data),
        .core_ack_i (core_ack), .core_result_i (core_result),
        .busy_o (busy), .err_o (err)
    );

    always #5 clk = ~clk;

    // Core stand-in: known SM4 vector for PT/CT, a fixed transform otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] x, input logic d);
        if (!d && x == PT) return CT;
        if (d && x == CT)  return PT;
        return {x[63:0], x[127:64]} ^ KEY ^ {128{d}};
    endfunction

    // Core model: capture each request, ack 32 cycles later (if enabled).
    always @(posedge clk) begin
        core_ack <= 1'b0;
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && m_en) begin
                core_ack    <= 1'b1;
                core_result <= core_fn(m_data, m_dec);
            end
        end else if (core_req) begin
            m_cnt  <= 32;
            m_data <= core_data;
            m_dec  <= core_dec;
            req_data.push_back(core_data);
            req_dec.push_back(core_dec);
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_iv(input logic [127:0] v);
        iv = v; iv_load = 1'b1;
        @(negedge clk);
        iv_load = 1'b0;
    endtask

    // Offer one block; returns at a negedge with ok set if it was accepted.
    task automatic offer(input logic [1:0] m, input logic d, input logic [127:0] x,
                         input int bound, output bit ok);
        ok = 1'b0;
        mode = m; dec = d; in_data = x; in_valid = 1'b1;
        for (int k = 0; k < bound; k++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input string tag, input logic [1:0] m, input logic d, input logic [127:0] x);
        bit ok;
        offer(m, d, x, 200, ok);
        check_eq({tag, "_accept"}, 128'(ok), 128'd1);
    endtask

    task automatic recv(input string tag, input logic [127:0] exp);
        bit ok = 1'b0;
        logic [127:0] d = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (out_valid) begin
                d  = out_data;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_valid"}, 128'(ok), 128'd1);
        if (ok) check_eq(tag, d, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc;
        int n;
        rst_n = 1'b0; mode = 2'b00; dec = 1'b0; iv = '0; iv_load = 1'b0;
        key_ready = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_in_ready",  128'(in_ready),  0);
        check_eq("rst_out_valid", 128'(out_valid), 0);
        check_eq("rst_core_req",  128'(core_req),  0);
        check_eq("rst_core_dec",  128'(core_dec),  0);
        check_eq("rst_busy",      128'(busy),      0);
        check_eq("rst_err",       128'(err),       0);
        check_eq("rst_core_data", core_data,       0);
        rst_n = 1'b1;
        @(negedge clk);

        // ECB encrypt of the standard vector
        req_data.delete(); req_dec.delete();
        send("ecb", 2'b00, 1'b0, PT);
        recv("ecb_out", CT);
        check_eq("ecb_core_in", (req_data.size() > 0) ? req_data[0] : 'x, PT);

        // CBC encrypt, IV = 0, same plaintext twice
        load_iv('0);
        req_data.delete(); req_dec.delete();
        send("cbc1", 2'b01, 1'b0, PT);
        recv("cbc1_out", CT);
        send("cbc2", 2'b01, 1'b0, PT);
        recv("cbc2_out", core_fn(PXC, 1'b0));
        check_eq("cbc2_core_in", (req_data.size() > 1) ? req_data[1] : 'x, PXC);

        // CBC decrypt, IV = 0, same ciphertext twice
        load_iv('0);
        send("cbcd1", 2'b01, 1'b1, CT);
        recv("cbcd1_out", PT);
        send("cbcd2", 2'b01, 1'b1, CT);
        recv("cbcd2_out", PXC);

        // CTR with low-field wrap; dec_i must be ignored
        load_iv(IVC);
        req_data.delete(); req_dec.delete();
        send("ctr1", 2'b10, 1'b1, {4{32'h11111111}});
        recv("ctr1_out", core_fn(IVC, 1'b0) ^ {4{32'h11111111}});
        send("ctr2", 2'b10, 1'b1, {4{32'h22222222}});
        recv("ctr2_out", core_fn('0, 1'b0) ^ {4{32'h22222222}});
        check_eq("ctr1_core_in", (req_data.size() > 0) ? req_data[0] : 'x, IVC);
        check_eq("ctr2_core_in", (req_data.size() > 1) ? req_data[1] : 'x, '0);
        check_eq("ctr_core_dec", (req_dec.size() > 1) ? 128'({req_dec[0], req_dec[1]}) : 'x, 0);

        // FIFO fill with consumer stalled: 6 offered, 4 accepted
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            offer(2'b00, 1'b0, 128'(i + 1), 100, ok);
            if (ok) acc++;
        end
        check_eq("fifo_accepted", 128'(acc), 4);
        #1;
        check_eq("fifo_full_ready", 128'(in_ready), 0);
        check_eq("fifo_full_valid", 128'(out_valid), 1);
        for (int i = 0; i < 4; i++) begin
            recv($sformatf("fifo_drain%0d", i), core_fn(128'(i + 1), 1'b0));
        end
        #1;
        check_eq("fifo_drained_ready", 128'(in_ready), 1);
        @(negedge clk);

        // Core never acks: error exactly TimeoutCycles after the request
        m_en = 1'b0;
        send("tmo", 2'b00, 1'b0, PT);
        n = 0;
        while (!core_req && n < 10) begin
            @(negedge clk); n++;
        end
        check_eq("tmo_req_seen", 128'(core_req), 1);
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk); n++;
        end
        check_eq("tmo_cycles", 128'(n), 64);
        check_eq("tmo_busy", 128'(busy), 0);
        check_eq("tmo_out_valid", 128'(out_valid), 0);
        m_en = 1'b1;
        load_iv('0);
        check_eq("tmo_err_cleared", 128'(err), 0);

        // Illegal mode sets the error and accepts nothing
        mode = 2'b11; in_valid = 1'b1; in_data = PT;
        #1;
        check_eq("ill_ready", 128'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0; mode = 2'b00;
        check_eq("ill_err", 128'(err), 1);
        check_eq("ill_busy", 128'(busy), 0);
        load_iv('0);
        check_eq("ill_err_cleared", 128'(err), 0);

        // Reset during WAIT with two blocks queued
        send("rw1", 2'b00, 1'b0, 128'h55);
        send("rw2", 2'b00, 1'b0, 128'h66);
        send("rw3", 2'b00, 1'b0, 128'h77);
        repeat (5) @(negedge clk);
        check_eq("rw_busy_before", 128'(busy), 1);
        check_eq("rw_valid_before", 128'(out_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rw_valid_rst", 128'(out_valid), 0);
        check_eq("rw_busy_rst", 128'(busy), 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("rw_late_ack_valid", 128'(out_valid), 0);
        check_eq("rw_late_ack_busy", 128'(busy), 0);

        // Recovery after reset
        send("post", 2'b00, 1'b0, PT);
        recv("post_out", CT);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sm4_mode_ctrl.md
SM4_MODE_CTRL -- requirements
Module: sm4_mode_ctrl

Interface
REQ-001 SHALL have parameter Depth, default 4: output FIFO depth in 128-bit blocks, legal range 2..16.
REQ-002 SHALL have parameter CtrWidth, default 32: CTR-mode incrementing field width, taken from the LSBs, legal range 8..128.
REQ-003 SHALL have parameter TimeoutCycles, default 64: maximum cycles to wait for core_ack_i.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_i  in  1  sole clock.
- rst_ni  in  1  reset, synchronous and active-low.
- mode_i  in  2  block mode: 00 ECB, 01 CBC, 10 CTR, 11 illegal.
- dec_i  in  1  1 = decrypt; ignored in CTR mode.
- iv_i  in  128  IV (CBC) or initial counter block (CTR).
- iv_load_i  in  1  pulse that loads iv_i into the chain register and clears err_o.
- key_ready_i  in  1  key expansion complete.
- in_valid_i  in  1  input block valid.
- in_ready_o  out  1  input block accepted when high together with in_valid_i.
- in_data_i  in  128  input block.
- out_valid_o  out  1  output block valid.
- out_ready_i  in  1  consumer ready.
- out_data_o  out  128  output block.
- core_req_o  out  1  one-cycle start pulse to the SM4 core.
- core_dec_o  out  1  decrypt select to the core.
- core_data_o  out  128  core input block.
- core_ack_i  in  1  core result valid, one-cycle pulse.
- core_result_i  in  128  core result.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky error flag.

Function
REQ-005 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-006 SHALL drive in_ready_o = IDLE & key_ready_i & (fifo_count < Depth) & !iv_load_i & (mode_i != 11).
REQ-007 On accept, SHALL latch mode_i, dec_i and in_data_i and go to ISSUE; mode changes while not in IDLE have no effect on the current block.
REQ-008 In ISSUE, SHALL assert core_req_o for exactly one cycle, holding core_data_o/core_dec_o stable until the ack or a timeout, then go to WAIT.
REQ-009 Core input selection:
- ECB: P.
- CBC encrypt: P xor chain.
- CBC decrypt: C.
- CTR: chain, with core_dec_o = 0.
REQ-010 On core_ack_i in WAIT, SHALL push the result into the FIFO and return to IDLE:
- ECB: push R.
- CBC encrypt: push R; chain <= R.
- CBC decrypt: push R xor chain; chain <= C.
- CTR: push R xor in_data; chain[CtrWidth-1:0] increments modulo 2^CtrWidth, upper bits unchanged.
REQ-011 Latency: accept at cycle T; core_req_o at T+1; ack at T+1+L; out_valid_o no earlier than T+2+L.
REQ-012 SHALL drive out_valid_o = FIFO not empty, with out_data_o = FIFO head; the FIFO pops on out_valid_o & out_ready_i, and push and pop in the same cycle are both honoured.
REQ-013 If a push occurs in the same cycle the FIFO is full, it SHALL be impossible by construction, because REQ-006 reserves a slot before issue.
REQ-014 In WAIT, SHALL count cycles; if TimeoutCycles elapse without core_ack_i, it SHALL set err_o, drop the block, leave chain unchanged and return to IDLE.
REQ-015 An in_valid_i while mode_i = 11 SHALL set err_o; no block is accepted.
REQ-016 iv_load_i in IDLE SHALL load chain and clear err_o, taking precedence over accept in that cycle; iv_load_i outside IDLE SHALL be ignored.
REQ-017 core_ack_i outside WAIT SHALL be ignored.

Reset
REQ-018 While rst_ni = 0 at a clk_i edge, SHALL enter IDLE and clear chain, the FIFO, the timeout counter and all registered state.
REQ-019 Output values under reset: in_ready_o, out_valid_o, core_req_o, core_dec_o, busy_o and err_o = 0; core_data_o = 0.
REQ-020 Reset mid-operation SHALL abort the in-flight block and discard FIFO contents; a late core_ack_i after reset SHALL be ignored.

Structure
REQ-021 Package sm4_mode_pkg SHALL hold the mode enum (ECB/CBC/CTR/ILLEGAL), the FSM state enum and the block width constant 128.
REQ-022 Exactly one sub-module, sm4_mode_fifo (synchronous-reset FIFO, Width = 128, Depth parameter, count output), SHALL be used; all mode logic stays in sm4_mode_ctrl.

Verification
REQ-023 Bench SHALL use a core model with a 32-cycle ack and key 0123456789abcdeffedcba9876543210. Required scenarios:
- ECB encrypt, P = 0123456789abcdeffedcba9876543210 -> out 681edf34d206965e86b3e94f536e4246.
- CBC encrypt, IV = 0, two blocks of the same P -> block 1 = 681edf34...4246; second core_data_o = P xor 681edf34...4246.
- CTR, IV = 000...00_FFFFFFFF, two blocks -> second core_data_o = 000...00_00000000 (low field wraps, upper 96 bits unchanged).
- out_ready_i = 0, Depth = 4, 6 blocks offered -> exactly 4 accepted, then in_ready_o = 0; draining restores acceptance.
- Core never acks -> err_o = 1 exactly TimeoutCycles cycles after core_req_o; busy_o = 0; iv_load_i clears err_o.
- rst_ni low during WAIT with 2 blocks queued -> next cycle out_valid_o = 0, busy_o = 0; a subsequent ack is ignored.
